done_sig_skid_fifo: RTL and testbench

- Parametrised successor to the single-word done/data obscuring stage.
- Sits between the memory-side done/data return and the controller FSM.
- Holds up to DEPTH returned words in a FIFO while the downstream buffer reports full, and replays them in order once it drains.
- Throttles the memory-side enable early, using a programmable margin, so in-flight returns are absorbed rather than dropped.

---
 rtl/done_sig_skid_fifo.sv | 143 ++++++++++++++
 tb/tb_done_sig_skid_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/done_sig_skid_fifo.sv
// Done/data skid FIFO between the memory return path and the controller FSM.
// Optional stall statistics are enabled with the DONE_SIG_SKID_STATS_EN macro.
module done_sig_skid_fifo #(
    parameter int unsigned BLOCK_WIDTH  = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_MARGIN = 1,
    parameter int unsigned CW           = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fsm_enabling,
    output logic                   real_enable,
    input  logic                   real_done,
    input  logic [BLOCK_WIDTH-1:0] real_data,
    input  logic                   buff_full,
    output logic                   fsm_virtual_done,
    output logic [BLOCK_WIDTH-1:0] fsm_virtual_data,
    output logic [CW-1:0]          hold_count,
    output logic                   hold_overflow
`ifdef DONE_SIG_SKID_STATS_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic                   overflow_q, overflow_d;
    logic [BLOCK_WIDTH-1:0] mem_q [DEPTH];

    logic          empty, full, bypass, push_req, push, pop;
    logic [CW-1:0] free_entries;

`ifdef DONE_SIG_SKID_STATS_EN
    logic [15:0] stall_q, stall_d;
`endif

    // Control state, pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PASS;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
`ifdef DONE_SIG_SKID_STATS_EN
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
`ifdef DONE_SIG_SKID_STATS_EN
            stall_q    <= stall_d;
`endif
        end
    end

    // Hold storage needs no reset; occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= real_data;
        end
    end

    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        overflow_d       = overflow_q;
        fsm_virtual_done = 1'b0;
        fsm_virtual_data = '0;
        real_enable      = 1'b0;

        empty        = (state_q == ST_PASS);
        full         = (state_q == ST_FULL);
        bypass       = empty & real_done & ~buff_full;
        pop          = ~empty & ~buff_full;
        push_req     = real_done & ~bypass;
        push         = push_req & (~full | pop);
        free_entries = CW'(DEPTH) - count_q;

        if (bypass) begin
            fsm_virtual_done = 1'b1;
            fsm_virtual_data = real_data;
        end else if (pop) begin
            fsm_virtual_done = 1'b1;
            fsm_virtual_data = mem_q[rd_ptr_q];
        end

        // Throttle early so in-flight returns find room; also cut when the first word parks.
        real_enable = fsm_enabling & (free_entries > CW'(AFULL_MARGIN))
                    & ~(empty & real_done & buff_full);

        if (push_req & full & ~pop) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        if (count_d == '0) begin
            state_d = ST_PASS;
        end else if (count_d == CW'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_DRAIN;
        end

`ifdef DONE_SIG_SKID_STATS_EN
        stall_d = stall_q;
        if (fsm_enabling & ~real_enable & (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
`endif
    end

    assign hold_count    = count_q;
    assign hold_overflow = overflow_q;
`ifdef DONE_SIG_SKID_STATS_EN
    assign stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_done_sig_skid_fifo.sv
// Directed bench for done_sig_skid_fifo (DEPTH=4, AFULL_MARGIN=1).
module tb_done_sig_skid_fifo;

    localparam int unsigned BW = 32;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst_n;
    logic          fsm_enabling;
    logic          real_enable;
    logic          real_done;
    logic [BW-1:0] real_data;
    logic          buff_full;
    logic          fsm_virtual_done;
    logic [BW-1:0] fsm_virtual_data;
    logic [CW-1:0] hold_count;
    logic          hold_overflow;
`ifdef DONE_SIG_SKID_STATS_EN
    logic [15:0]   stall_cycles;
`endif

    int n_pass  = 0;
    int n_total = 0;

    done_sig_skid_fifo #(
        .BLOCK_WIDTH (BW),
        .DEPTH       (4),
        .AFULL_MARGIN(1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fsm_enabling    (fsm_enabling),
        .real_enable     (real_enable),
        .real_done       (real_done),
        .real_data       (real_data),
        .buff_full       (buff_full),
        .fsm_virtual_done(fsm_virtual_done),
        .fsm_virtual_data(fsm_virtual_data),
        .hold_count      (hold_count),
        .hold_overflow   (hold_overflow)
`ifdef DONE_SIG_SKID_STATS_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge, let combinational outputs settle.
    task automatic drive(input logic en, input logic done, input logic [31:0] data,
                         input logic full);
        @(negedge clk);
        fsm_enabling = en;
        real_done    = done;
        real_data    = data;
        buff_full    = full;
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        fsm_enabling = 1'b1;
        real_done    = 1'b0;
        real_data    = '0;
        buff_full    = 1'b0;
        #12;
        chk("rst_count", 32'(hold_count), 32'd0);
        chk("rst_vdone", 32'(fsm_virtual_done), 32'd0);
        chk("rst_vdata", fsm_virtual_data, 32'd0);
        chk("rst_ovf", 32'(hold_overflow), 32'd0);
        chk("rst_enable", 32'(real_enable), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass
        drive(1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
        chk("byp_vdone", 32'(fsm_virtual_done), 32'd1);
        chk("byp_vdata", fsm_virtual_data, 32'hA5A5_0001);
        chk("byp_enable", 32'(real_enable), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("byp_count", 32'(hold_count), 32'd0);
        chk("byp_enable_follow", 32'(real_enable), 32'd0);

        // Park three words, throttle behaviour
        drive(1'b1, 1'b1, 32'h11, 1'b1);
        chk("park_vdone0", 32'(fsm_virtual_done), 32'd0);
        chk("park_cut", 32'(real_enable), 32'd0);
        drive(1'b1, 1'b1, 32'h22, 1'b1);
        chk("park_count1", 32'(hold_count), 32'd1);
        chk("park_en1", 32'(real_enable), 32'd1);
        drive(1'b1, 1'b1, 32'h33, 1'b1);
        chk("park_en2", 32'(real_enable), 32'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("park_count3", 32'(hold_count), 32'd3);
        chk("park_en3", 32'(real_enable), 32'd0);
        chk("park_vdone3", 32'(fsm_virtual_done), 32'd0);

        // Replay in order
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rep0_data", fsm_virtual_data, 32'h11);
        chk("rep0_en", 32'(real_enable), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rep1_data", fsm_virtual_data, 32'h22);
        chk("rep1_count", 32'(hold_count), 32'd2);
        chk("rep1_en", 32'(real_enable), 32'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rep2_vdone", 32'(fsm_virtual_done), 32'd1);
        chk("rep2_data", fsm_virtual_data, 32'h33);
        drive(1'b1, 1'b1, 32'h77, 1'b0);
        chk("rep_pass_count", 32'(hold_count), 32'd0);
        chk("rep_pass_bypass", fsm_virtual_data, 32'h77);

        // Simultaneous push and pop
        drive(1'b1, 1'b1, 32'h44, 1'b1);
        drive(1'b1, 1'b1, 32'h55, 1'b1);
        drive(1'b1, 1'b1, 32'h66, 1'b0);
        chk("pp_count_before", 32'(hold_count), 32'd2);
        chk("pp_head", fsm_virtual_data, 32'h44);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("pp_count_after", 32'(hold_count), 32'd2);
        chk("pp_next0", fsm_virtual_data, 32'h55);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("pp_next1", fsm_virtual_data, 32'h66);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("pp_empty_vdone", 32'(fsm_virtual_done), 32'd0);
        chk("pp_empty_vdata", fsm_virtual_data, 32'd0);

        // Overflow
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 32'(i), 1'b1);
        end
        drive(1'b1, 1'b1, 32'h99, 1'b1);
        chk("ovf_count_full", 32'(hold_count), 32'd4);
        chk("ovf_en_full", 32'(real_enable), 32'd0);
        chk("ovf_not_yet", 32'(hold_overflow), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("ovf_flag", 32'(hold_overflow), 32'd1);
        chk("ovf_count", 32'(hold_count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            chk("ovf_drain", fsm_virtual_data, 32'(i));
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("ovf_no_99", 32'(fsm_virtual_done), 32'd0);
        chk("ovf_sticky", 32'(hold_overflow), 32'd1);

        // Async reset while draining
        drive(1'b1, 1'b1, 32'hAA, 1'b1);
        drive(1'b1, 1'b1, 32'hBB, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("ar_count_pre", 32'(hold_count), 32'd2);
        buff_full = 1'b0;
        #1;
        chk("ar_head_pre", fsm_virtual_data, 32'hAA);
        rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(hold_count), 32'd0);
        chk("ar_vdone", 32'(fsm_virtual_done), 32'd0);
        chk("ar_vdata", fsm_virtual_data, 32'd0);
        chk("ar_ovf", 32'(hold_overflow), 32'd0);
        chk("ar_enable", 32'(real_enable), 32'd1);
`ifdef DONE_SIG_SKID_STATS_EN
        chk("ar_stall", 32'(stall_cycles), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("ar_post_vdone", 32'(fsm_virtual_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
